// File: rtl/load_store_unit_pkg.sv
// Shared types and Funct3 decode helpers for the load/store unit.
package load_store_unit_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {LSU_IDLE, LSU_BUS, LSU_DONE} lsu_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   // Unlisted encodings fall through to a word access.
   function automatic lsu_size_e decode_size(input logic [2:0] f3);
      case (f3)
         FUNCT3_LB, FUNCT3_LBU: decode_size = SZ_B;
         FUNCT3_LH, FUNCT3_LHU: decode_size = SZ_H;
         default:               decode_size = SZ_W;
      endcase
   endfunction

   function automatic logic funct3_unsigned(input logic [2:0] f3);
      funct3_unsigned = (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
   endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store enables/replication, load lane select/extension, misalign check.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0] offset,
   input  lsu_size_e  size,
   input  logic       load_unsigned,
   input  word_t      store_data,
   input  word_t      bus_word,
   output logic [3:0] be,
   output word_t      wdata,
   output word_t      load_data,
   output logic       misaligned
);

   word_t lane;

   assign lane = bus_word >> {offset, 3'b000};

   always_comb begin
      be         = 4'b1111;
      wdata      = store_data;
      load_data  = lane;
      misaligned = 1'b0;
      case (size)
         SZ_B: begin
            be        = 4'(1) << offset;
            wdata     = {4{store_data[7:0]}};
            load_data = load_unsigned ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         end
         SZ_H: begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{store_data[15:0]}};
            load_data  = load_unsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            misaligned = offset[0];
         end
         default: begin
            misaligned = |offset;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: captures a load/store, runs a req/ack bus transfer with timeout, stalls the core.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr,
   output logic        TimeoutErr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [29:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned   CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [29:0]      waddr_q;
   logic [1:0]       off_q;
   lsu_size_e        size_q;
   logic             uns_q;
   logic             we_q;
   logic [3:0]       be_q;
   word_t            wdata_q;
   word_t            rdata_q;
   logic             timeout_q;

   logic             access;
   logic             capture;
   logic             ack_done;
   logic             expire;
   logic [1:0]       sel_off;
   lsu_size_e        sel_size;
   logic             sel_uns;
   logic [3:0]       al_be;
   word_t            al_wdata;
   word_t            al_load;
   logic             al_mis;

   assign access = MemRead | MemWrite;

   // One aligner serves both phases: live request in IDLE, captured request while on the bus.
   assign sel_off  = (state_q == LSU_IDLE) ? ALUResult[1:0] : off_q;
   assign sel_size = (state_q == LSU_IDLE) ? decode_size(Funct3) : size_q;
   assign sel_uns  = (state_q == LSU_IDLE) ? funct3_unsigned(Funct3) : uns_q;

   lsu_align u_align (
      .offset        (sel_off),
      .size          (sel_size),
      .load_unsigned (sel_uns),
      .store_data    (WriteData),
      .bus_word      (bus_rdata),
      .be            (al_be),
      .wdata         (al_wdata),
      .load_data     (al_load),
      .misaligned    (al_mis)
   );

   always_comb begin
      state_d     = state_q;
      Stall       = 1'b0;
      MisalignErr = 1'b0;
      TimeoutErr  = 1'b0;
      ReadData    = rdata_q;
      bus_req     = 1'b0;
      bus_we      = 1'b0;
      bus_addr    = '0;
      bus_be      = '0;
      bus_wdata   = '0;
      capture     = 1'b0;
      ack_done    = 1'b0;
      expire      = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (access) begin
               if (al_mis) begin
                  MisalignErr = 1'b1;
                  ReadData    = '0;
               end else begin
                  Stall   = 1'b1;
                  capture = 1'b1;
                  state_d = LSU_BUS;
               end
            end
         end
         LSU_BUS: begin
            bus_req   = 1'b1;
            Stall     = 1'b1;
            bus_we    = we_q;
            bus_addr  = waddr_q;
            bus_be    = be_q;
            bus_wdata = wdata_q;
            if (bus_ack) begin
               ack_done = 1'b1;
               state_d  = LSU_DONE;
            end else if (cnt_q == CNT_LAST) begin
               expire  = 1'b1;
               state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            TimeoutErr = timeout_q;
            state_d    = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= LSU_IDLE;
      else       state_q <= state_d;
   end

   // Capture registers, timeout counter and load result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         waddr_q   <= '0;
         off_q     <= '0;
         size_q    <= SZ_B;
         uns_q     <= 1'b0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (capture) begin
            waddr_q <= ALUResult[31:2];
            off_q   <= ALUResult[1:0];
            size_q  <= sel_size;
            uns_q   <= sel_uns;
            we_q    <= MemWrite;
            be_q    <= al_be;
            wdata_q <= MemWrite ? al_wdata : '0;
         end
         if (state_q == LSU_BUS && state_d == LSU_BUS) cnt_q <= cnt_q + CNT_W'(1);
         else                                          cnt_q <= '0;
         if (ack_done && !we_q) rdata_q <= al_load;
         else if (expire)       rdata_q <= '0;
         timeout_q <= expire;
      end
   end

endmodule
